// File: rtl/avalon_st_pkg.sv
// -----------------------------------------------------------------------------
// avalon_st_pkg
//
// Shared definitions for the two-sink Avalon-ST packet arbiter.
//   - arb_state_e : arbiter states (IDLE / GRANT0 / GRANT1)
//   - SINK_IDX_W  : width of a sink index (two sinks -> 1 bit)
//   - grant_state : maps a sink index to the GRANT state that serves it
//
// Optional feature macro used by the files that import this package:
//   AVALON_ST_ARB_CHANNEL_EN (adds the aso_out0_channel output)
// -----------------------------------------------------------------------------
package avalon_st_pkg;

    localparam int SINK_IDX_W = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_e;

    function automatic arb_state_e grant_state(input logic [SINK_IDX_W-1:0] idx);
        return (idx == '0) ? GRANT0 : GRANT1;
    endfunction

endpackage

// File: rtl/avalon_st_out_reg.sv
// -----------------------------------------------------------------------------
// avalon_st_out_reg
//
// Single-entry valid/ready pipeline register that drives the arbiter's
// Avalon-ST source. A beat written with load_i appears on the outputs on the
// next cycle and stays put until the downstream sink takes it.
//
// Ports:
//   clk_i       in   clock, rising edge
//   rst_n_i     in   synchronous active-low reset (clears valid and payload)
//   load_i      in   write a new beat this cycle
//   data_i      in   beat data    (DATA_WIDTH)
//   sop_i       in   beat start-of-packet
//   eop_i       in   beat end-of-packet
//   chan_i      in   sink index of the beat (only with AVALON_ST_ARB_CHANNEL_EN)
//   ready_i     in   downstream ready
//   can_load_o  out  a beat may be written this cycle (~valid | ready)
//   valid_o     out  registered valid
//   data_o      out  registered data
//   sop_o       out  registered start-of-packet
//   eop_o       out  registered end-of-packet
//   chan_o      out  registered sink index (only with AVALON_ST_ARB_CHANNEL_EN)
//
// Feature macro: AVALON_ST_ARB_CHANNEL_EN
// -----------------------------------------------------------------------------
module avalon_st_out_reg
    import avalon_st_pkg::*;
#(
    parameter int DATA_WIDTH = 32
)
(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  sop_i,
    input  logic                  eop_i,
`ifdef AVALON_ST_ARB_CHANNEL_EN
    input  logic [SINK_IDX_W-1:0] chan_i,
    output logic [SINK_IDX_W-1:0] chan_o,
`endif
    input  logic                  ready_i,
    output logic                  can_load_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  sop_o,
    output logic                  eop_o
);

    logic                  valid_q;
    logic                  valid_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  sop_q;
    logic                  eop_q;
`ifdef AVALON_ST_ARB_CHANNEL_EN
    logic [SINK_IDX_W-1:0] chan_q;
`endif

    // A load wins over a drain so back-to-back beats keep valid high and the
    // stage sustains one beat per cycle.
    always_comb begin
        valid_d = valid_q;
        if (load_i) begin
            valid_d = 1'b1;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Payload only changes on a load, so it holds while the sink stalls and
    // keeps its last value once drained.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
`ifdef AVALON_ST_ARB_CHANNEL_EN
            chan_q  <= '0;
`endif
        end else begin
            valid_q <= valid_d;
            if (load_i) begin
                data_q <= data_i;
                sop_q  <= sop_i;
                eop_q  <= eop_i;
`ifdef AVALON_ST_ARB_CHANNEL_EN
                chan_q <= chan_i;
`endif
            end
        end
    end

    assign can_load_o = ~valid_q | ready_i;
    assign valid_o    = valid_q;
    assign data_o     = data_q;
    assign sop_o      = sop_q;
    assign eop_o      = eop_q;
`ifdef AVALON_ST_ARB_CHANNEL_EN
    assign chan_o     = chan_q;
`endif

endmodule

// File: rtl/avalon_st_packet_arbiter.sv
// -----------------------------------------------------------------------------
// avalon_st_packet_arbiter
//
// Two-sink to one-source Avalon-ST packet arbiter (readyLatency 0). A sink is
// granted at a packet boundary and keeps the grant until its EOP beat is
// accepted; packets never interleave. When both sinks request in the same
// arbitration cycle a round-robin pointer picks the winner and then moves to
// the other sink. Every packet is followed by one IDLE arbitration cycle.
// The output goes through a one-beat register (one cycle latency).
//
// Ports:
//   clock_clk              in   clock, rising edge
//   reset_reset_n          in   synchronous active-low reset
//   asi_in0_*              sink 0: data/valid/startofpacket/endofpacket in,
//                          ready out
//   asi_in1_*              sink 1: same as sink 0
//   aso_out0_*             source: data/valid/startofpacket/endofpacket out,
//                          ready in
//   aso_out0_channel       out  index of the sink that supplied the current
//                          output beat (only with AVALON_ST_ARB_CHANNEL_EN)
//
// Feature macro: AVALON_ST_ARB_CHANNEL_EN
// -----------------------------------------------------------------------------
module avalon_st_packet_arbiter
    import avalon_st_pkg::*;
#(
    parameter int DATA_WIDTH = 32
)
(
    input  logic                  clock_clk,
    input  logic                  reset_reset_n,

    input  logic [DATA_WIDTH-1:0] asi_in0_data,
    input  logic                  asi_in0_valid,
    output logic                  asi_in0_ready,
    input  logic                  asi_in0_startofpacket,
    input  logic                  asi_in0_endofpacket,

    input  logic [DATA_WIDTH-1:0] asi_in1_data,
    input  logic                  asi_in1_valid,
    output logic                  asi_in1_ready,
    input  logic                  asi_in1_startofpacket,
    input  logic                  asi_in1_endofpacket,

    output logic [DATA_WIDTH-1:0] aso_out0_data,
    output logic                  aso_out0_valid,
    input  logic                  aso_out0_ready,
    output logic                  aso_out0_startofpacket,
`ifdef AVALON_ST_ARB_CHANNEL_EN
    output logic [SINK_IDX_W-1:0] aso_out0_channel,
`endif
    output logic                  aso_out0_endofpacket
);

    arb_state_e            state_q;
    logic [SINK_IDX_W-1:0] rr_q;

    logic                  can_load;
    logic                  accept0;
    logic                  accept1;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_sop;
    logic                  load_eop;
`ifdef AVALON_ST_ARB_CHANNEL_EN
    logic [SINK_IDX_W-1:0] load_idx;
`endif

    // Ready is masked by reset so an upstream source never sees a beat
    // "taken" in a cycle whose clock edge resets the arbiter.
    assign asi_in0_ready = reset_reset_n && (state_q == GRANT0) && can_load;
    assign asi_in1_ready = reset_reset_n && (state_q == GRANT1) && can_load;

    assign accept0 = asi_in0_ready & asi_in0_valid;
    assign accept1 = asi_in1_ready & asi_in1_valid;
    assign load    = accept0 | accept1;

    // Only the granted sink can be accepted, so the payload mux just follows
    // the state; its value is ignored whenever load is low.
    always_comb begin
        load_data = asi_in0_data;
        load_sop  = asi_in0_startofpacket;
        load_eop  = asi_in0_endofpacket;
        if (state_q == GRANT1) begin
            load_data = asi_in1_data;
            load_sop  = asi_in1_startofpacket;
            load_eop  = asi_in1_endofpacket;
        end
    end

`ifdef AVALON_ST_ARB_CHANNEL_EN
    assign load_idx = (state_q == GRANT1) ? SINK_IDX_W'(1) : '0;
`endif

    // Arbitration FSM. SOP is never looked at: only an accepted EOP ends a
    // grant, and a granted sink that drops valid keeps the grant indefinitely.
    always_ff @(posedge clock_clk) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (asi_in0_valid && asi_in1_valid) begin
                        state_q <= grant_state(rr_q);
                        rr_q    <= ~rr_q;
                    end else if (asi_in0_valid) begin
                        state_q <= grant_state('0);
                    end else if (asi_in1_valid) begin
                        state_q <= grant_state(SINK_IDX_W'(1));
                    end
                end
                GRANT0: begin
                    if (accept0 && asi_in0_endofpacket) begin
                        state_q <= IDLE;
                    end
                end
                GRANT1: begin
                    if (accept1 && asi_in1_endofpacket) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    avalon_st_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk_i      (clock_clk),
        .rst_n_i    (reset_reset_n),
        .load_i     (load),
        .data_i     (load_data),
        .sop_i      (load_sop),
        .eop_i      (load_eop),
`ifdef AVALON_ST_ARB_CHANNEL_EN
        .chan_i     (load_idx),
        .chan_o     (aso_out0_channel),
`endif
        .ready_i    (aso_out0_ready),
        .can_load_o (can_load),
        .valid_o    (aso_out0_valid),
        .data_o     (aso_out0_data),
        .sop_o      (aso_out0_startofpacket),
        .eop_o      (aso_out0_endofpacket)
    );

endmodule

// File: tb/tb_avalon_st_packet_arbiter.sv
// -----------------------------------------------------------------------------
// tb_avalon_st_packet_arbiter
//
// Self-checking bench for avalon_st_packet_arbiter. Sinks are fed from beat
// queues; a packet-level reference (owner / pointer / one output slot) tracks
// what the outputs must be and is compared every cycle, and each directed
// scenario also checks hand-derived beat orders and cycle positions.
// Define AVALON_ST_ARB_CHANNEL_EN to also cover aso_out0_channel.
// -----------------------------------------------------------------------------
module tb_avalon_st_packet_arbiter;

    localparam int DW = 32;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic          ch;
        logic          xfer;
    } logEnt_t;

    logic          clk      = 1'b0;
    logic          rstN     = 1'b0;
    logic [DW-1:0] in0Data  = '0;
    logic          in0Valid = 1'b0;
    logic          in0Sop   = 1'b0;
    logic          in0Eop   = 1'b0;
    logic          in0Ready;
    logic [DW-1:0] in1Data  = '0;
    logic          in1Valid = 1'b0;
    logic          in1Sop   = 1'b0;
    logic          in1Eop   = 1'b0;
    logic          in1Ready;
    logic [DW-1:0] outData;
    logic          outValid;
    logic          outReady = 1'b1;
    logic          outSop;
    logic          outEop;
`ifdef AVALON_ST_ARB_CHANNEL_EN
    logic          outCh;
`endif

    // Bench-side sink queues and controls
    beat_t   q0[$];
    beat_t   q1[$];
    logEnt_t outLog[$];
    bit      hold0 = 1'b0;
    bit      chkEn = 1'b0;
    int      cyc   = 0;
    int      checks = 0;
    int      errors = 0;

    // Reference state: owner -1 means nobody holds the grant
    int            mOwner    = -1;
    int            mPtr      = 0;
    bit            mOutValid = 1'b0;
    logic [DW-1:0] mOutData  = '0;
    logic          mOutSop   = 1'b0;
    logic          mOutEop   = 1'b0;
    logic          mOutCh    = 1'b0;

    bit            prevHold = 1'b0;
    logic [DW-1:0] prevData = '0;

    always #5 clk = ~clk;

    avalon_st_packet_arbiter #(
        .DATA_WIDTH (DW)
    ) dut (
        .clock_clk              (clk),
        .reset_reset_n          (rstN),
        .asi_in0_data           (in0Data),
        .asi_in0_valid          (in0Valid),
        .asi_in0_ready          (in0Ready),
        .asi_in0_startofpacket  (in0Sop),
        .asi_in0_endofpacket    (in0Eop),
        .asi_in1_data           (in1Data),
        .asi_in1_valid          (in1Valid),
        .asi_in1_ready          (in1Ready),
        .asi_in1_startofpacket  (in1Sop),
        .asi_in1_endofpacket    (in1Eop),
        .aso_out0_data          (outData),
        .aso_out0_valid         (outValid),
        .aso_out0_ready         (outReady),
        .aso_out0_startofpacket (outSop),
`ifdef AVALON_ST_ARB_CHANNEL_EN
        .aso_out0_channel       (outCh),
`endif
        .aso_out0_endofpacket   (outEop)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic bit expReady(input int n);
        return rstN && (mOwner == n) && (!mOutValid || outReady);
    endfunction

    task automatic drive();
        in0Valid = (q0.size() > 0) && !hold0;
        if (q0.size() > 0) begin
            in0Data = q0[0].data; in0Sop = q0[0].sop; in0Eop = q0[0].eop;
        end else begin
            in0Data = '0; in0Sop = 1'b0; in0Eop = 1'b0;
        end
        in1Valid = (q1.size() > 0);
        if (q1.size() > 0) begin
            in1Data = q1[0].data; in1Sop = q1[0].sop; in1Eop = q1[0].eop;
        end else begin
            in1Data = '0; in1Sop = 1'b0; in1Eop = 1'b0;
        end
    endtask

    // Packet-level reference update from the inputs sampled at this edge
    task automatic modelUpdate();
        bit    acc0;
        bit    acc1;
        beat_t b;
        b = '{data: '0, sop: 1'b0, eop: 1'b0};
        if (!rstN) begin
            mOwner = -1; mPtr = 0; mOutValid = 1'b0;
            mOutData = '0; mOutSop = 1'b0; mOutEop = 1'b0; mOutCh = 1'b0;
        end else begin
            acc0 = expReady(0) && in0Valid;
            acc1 = expReady(1) && in1Valid;
            if (acc0) b = q0.pop_front();
            if (acc1) b = q1.pop_front();
            if (acc0 || acc1) begin
                mOutValid = 1'b1;
                mOutData  = b.data; mOutSop = b.sop; mOutEop = b.eop;
                mOutCh    = acc1;
            end else if (outReady) begin
                mOutValid = 1'b0;
            end
            if (mOwner < 0) begin
                if (in0Valid && in1Valid) begin
                    mOwner = mPtr;
                    mPtr   = 1 - mPtr;
                end else if (in0Valid) begin
                    mOwner = 0;
                end else if (in1Valid) begin
                    mOwner = 1;
                end
            end else if ((acc0 || acc1) && b.eop) begin
                mOwner = -1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        modelUpdate();
        #1;
        drive();
    endtask

    task automatic applyStimulus(input int sink, input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.data = base + DW'(i);
            b.sop  = (i == 0);
            b.eop  = (i == n - 1);
            if (sink == 0) q0.push_back(b);
            else q1.push_back(b);
        end
        drive();
    endtask

    task automatic waitIdle(input int budget, input string name);
        int n;
        n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && mOwner == -1 && !mOutValid) && n < budget) begin
            step();
            n++;
        end
        checkOutput(name, (n < budget) ? 32'd1 : 32'd0, 32'd1);
        step();
    endtask

    task automatic doReset();
        rstN = 1'b0;
        q0.delete(); q1.delete();
        drive();
        step(); step();
        rstN = 1'b1;
        drive();
    endtask

    // Per-cycle comparison against the reference plus the stall-hold rule
    always @(negedge clk) begin
        if (chkEn) begin
            checkOutput("in0_ready", in0Ready, expReady(0));
            checkOutput("in1_ready", in1Ready, expReady(1));
            checkOutput("out_valid", outValid, mOutValid);
            checkOutput("out_data", outData, mOutData);
            checkOutput("out_sop", outSop, mOutSop);
            checkOutput("out_eop", outEop, mOutEop);
`ifdef AVALON_ST_ARB_CHANNEL_EN
            checkOutput("out_channel", outCh, mOutCh);
`endif
            if (prevHold) begin
                checkOutput("hold_valid", outValid, 1);
                checkOutput("hold_data", outData, prevData);
            end
            if (outValid === 1'b1) begin
`ifdef AVALON_ST_ARB_CHANNEL_EN
                outLog.push_back('{cyc: cyc, data: outData, sop: outSop, eop: outEop, ch: outCh, xfer: outReady});
`else
                outLog.push_back('{cyc: cyc, data: outData, sop: outSop, eop: outEop, ch: 1'b0, xfer: outReady});
`endif
            end
            prevHold = rstN && (outValid === 1'b1) && !outReady;
            prevData = outData;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int s;
        int n;
        int pat [5] = '{1, 0, 0, 1, 1};
        logEnt_t sops[$];

        drive();
        step(); step();
        chkEn = 1'b1;
        checkOutput("rst_out_valid", outValid, 0);
        checkOutput("rst_out_data", outData, 0);
        checkOutput("rst_in0_ready", in0Ready, 0);
        checkOutput("rst_in1_ready", in1Ready, 0);
        rstN = 1'b1;
        drive();

        // Sink 0 alone, 4-beat packet
        $display("[TB] sink0 4-beat packet");
        outLog.delete();
        s = cyc;
        applyStimulus(0, 32'hA0, 4);
        waitIdle(40, "s1_drain");
        checkOutput("s1_len", outLog.size(), 4);
        for (int i = 0; i < 4 && i < outLog.size(); i++) begin
            checkOutput("s1_cyc", outLog[i].cyc, s + 2 + i);
            checkOutput("s1_data", outLog[i].data, 32'hA0 + i);
            checkOutput("s1_sop", outLog[i].sop, (i == 0) ? 1 : 0);
            checkOutput("s1_eop", outLog[i].eop, (i == 3) ? 1 : 0);
        end

        // Both sinks from reset, sink0 wins, one idle cycle, then sink1
        $display("[TB] both sinks from reset");
        doReset();
        outLog.delete();
        s = cyc;
        applyStimulus(0, 32'h10, 3);
        applyStimulus(1, 32'h20, 3);
        waitIdle(60, "s2_drain");
        checkOutput("s2_len", outLog.size(), 6);
        if (outLog.size() == 6) begin
            checkOutput("s2_first_cyc", outLog[0].cyc, s + 2);
            checkOutput("s2_d0", outLog[0].data, 32'h10);
            checkOutput("s2_d2", outLog[2].data, 32'h12);
            checkOutput("s2_d3", outLog[3].data, 32'h20);
            checkOutput("s2_d5", outLog[5].data, 32'h22);
            checkOutput("s2_gap", outLog[3].cyc - outLog[2].cyc, 2);
        end

        // Reset in the middle of a 5-beat packet (pointer is at sink 1 here)
        $display("[TB] reset mid-packet");
        outLog.delete();
        s = cyc;
        applyStimulus(0, 32'hB0, 5);
        step(); step(); step();
        rstN = 1'b0;
        drive();
        step();
        rstN = 1'b1;
        q0.delete();
        drive();
        checkOutput("s5_valid_after_rst", outValid, 0);
        checkOutput("s5_data_after_rst", outData, 0);
        checkOutput("s5_eop_after_rst", outEop, 0);
        checkOutput("s5_in0_ready_idle", in0Ready, 0);
        waitIdle(40, "s5_drain");
        checkOutput("s5_len", outLog.size(), 2);
        if (outLog.size() == 2) begin
            checkOutput("s5_d0", outLog[0].data, 32'hB0);
            checkOutput("s5_d1", outLog[1].data, 32'hB1);
        end
        outLog.delete();
        applyStimulus(0, 32'h60, 1);
        applyStimulus(1, 32'h61, 1);
        waitIdle(40, "s5b_drain");
        checkOutput("s5_ptr_len", outLog.size(), 2);
        if (outLog.size() == 2) begin
            checkOutput("s5_ptr_first", outLog[0].data, 32'h60);
            checkOutput("s5_ptr_second", outLog[1].data, 32'h61);
        end

        // Both sinks continuously offering 2-beat packets
        $display("[TB] round-robin alternation");
        doReset();
        outLog.delete();
        for (int p = 0; p < 4; p++) begin
            applyStimulus(0, 32'h3000 + 32'(p * 16), 2);
            applyStimulus(1, 32'h4000 + 32'(p * 16), 2);
        end
        waitIdle(200, "s3_drain");
        checkOutput("s3_len", outLog.size(), 16);
        sops.delete();
        foreach (outLog[i]) if (outLog[i].sop) sops.push_back(outLog[i]);
        checkOutput("s3_packets", sops.size(), 8);
        for (int k = 0; k < 8 && k < sops.size(); k++) begin
            checkOutput("s3_src", sops[k].data[15:12], (k % 2 == 0) ? 3 : 4);
        end

        // Downstream ready toggling 1,0,0,1,1
        $display("[TB] backpressure");
        outLog.delete();
        outReady = 1'b1;
        applyStimulus(0, 32'hC0, 3);
        for (int k = 1; k < 5; k++) begin
            step();
            outReady = pat[k][0];
            drive();
        end
        outReady = 1'b1;
        drive();
        waitIdle(40, "s4_drain");
        checkOutput("s4_valid_cycles", outLog.size(), 4);
        n = 0;
        foreach (outLog[i]) begin
            if (outLog[i].xfer) begin
                checkOutput("s4_xfer_data", outLog[i].data, 32'hC0 + n);
                n++;
            end
        end
        checkOutput("s4_xfers", n, 3);

        // Sink 1 single-beat packet
        $display("[TB] single-beat packet");
        outLog.delete();
        s = cyc;
        applyStimulus(1, 32'h55, 1);
        waitIdle(20, "s6_drain");
        checkOutput("s6_len", outLog.size(), 1);
        if (outLog.size() == 1) begin
            checkOutput("s6_cyc", outLog[0].cyc, s + 2);
            checkOutput("s6_data", outLog[0].data, 32'h55);
            checkOutput("s6_sop", outLog[0].sop, 1);
            checkOutput("s6_eop", outLog[0].eop, 1);
`ifdef AVALON_ST_ARB_CHANNEL_EN
            checkOutput("s6_channel", outLog[0].ch, 1);
`endif
        end

        // Granted sink drops valid mid-packet while the other sink waits
        $display("[TB] mid-packet valid gap");
        outLog.delete();
        applyStimulus(0, 32'hE0, 3);
        step(); step();
        hold0 = 1'b1;
        applyStimulus(1, 32'hF0, 1);
        step(); step();
        hold0 = 1'b0;
        drive();
        waitIdle(40, "s7_drain");
        checkOutput("s7_len", outLog.size(), 4);
        if (outLog.size() == 4) begin
            checkOutput("s7_d1", outLog[1].data, 32'hE1);
            checkOutput("s7_d2", outLog[2].data, 32'hE2);
            checkOutput("s7_d3", outLog[3].data, 32'hF0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/avalon_st_packet_arbiter.md
AVALON_ST_PACKET_ARBITER -- requirements
Module: avalon_st_packet_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the data width of all Avalon-ST interfaces.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset.
REQ-003 The block SHALL have the following ports:
- clock_clk  in  1  block clock; all logic on its rising edge
- reset_reset_n  in  1  synchronous active-low reset
- asi_in0_data  in  DATA_WIDTH  sink 0 data
- asi_in0_valid  in  1  sink 0 valid
- asi_in0_ready  out  1  sink 0 ready
- asi_in0_startofpacket  in  1  sink 0 SOP
- asi_in0_endofpacket  in  1  sink 0 EOP
- asi_in1_data, asi_in1_valid, asi_in1_ready, asi_in1_startofpacket, asi_in1_endofpacket  same as sink 0, for sink 1
- aso_out0_data  out  DATA_WIDTH  source data
- aso_out0_valid  out  1  source valid
- aso_out0_ready  in  1  source ready
- aso_out0_startofpacket  out  1  source SOP
- aso_out0_endofpacket  out  1  source EOP

Function
REQ-004 All interfaces SHALL use readyLatency 0: a beat transfers on any cycle where valid and ready are both 1.
REQ-005 The arbiter SHALL have three states: IDLE, GRANT0 and GRANT1.
REQ-006 In IDLE, asi_in0_ready and asi_in1_ready SHALL be 0.
REQ-007 In IDLE with exactly one sink valid, the next state SHALL be the GRANT state of that sink.
REQ-008 In IDLE with both sinks valid, the next state SHALL be the GRANT state of the sink selected by the round-robin pointer, and the pointer SHALL then select the other sink.
REQ-009 In IDLE with neither sink valid, the arbiter SHALL stay in IDLE.
REQ-010 In GRANTn, asi_inn_ready SHALL be (~out_valid_r | aso_out0_ready), and the other sink's ready SHALL be 0.
REQ-011 An accepted GRANTn beat SHALL load data, SOP and EOP into the output register, which SHALL drive aso_out0_* with exactly one cycle latency.
REQ-012 When a GRANTn beat with EOP=1 is accepted, the next state SHALL be IDLE, giving one idle arbitration cycle between packets.
REQ-013 Packets SHALL NOT interleave: the grant holds from GRANTn entry until the EOP beat is accepted, regardless of the other sink's valid.
REQ-014 Packet boundaries SHALL be set only by EOP; SOP SHALL be forwarded unmodified, and a missing or duplicate SOP SHALL NOT change arbitration.
REQ-015 out_valid_r SHALL set on an accepted beat and clear when aso_out0_ready=1 with no new beat accepted; simultaneous drain and load SHALL keep it at 1 and sustain one beat per cycle.
REQ-016 If aso_out0_ready=0 while out_valid_r=1, the output register and all aso_out0_* SHALL hold stable.
REQ-017 A single-beat packet (SOP=EOP=1) SHALL be accepted in one GRANT cycle and then return to IDLE.
REQ-018 A granted sink deasserting valid mid-packet SHALL keep the grant; the arbiter waits with no timeout.

Reset
REQ-019 While reset_reset_n=0 at a clock edge, the block SHALL enter IDLE, point round-robin at sink 0, and clear out_valid_r.
REQ-020 During and after reset, aso_out0_valid, asi_in0_ready and asi_in1_ready SHALL be 0; aso_out0_data, SOP and EOP SHALL be 0.
REQ-021 Reset asserted mid-packet SHALL abandon the packet; no beat of it SHALL be emitted after reset.

Configuration
REQ-022 With macro AVALON_ST_ARB_CHANNEL_EN defined, port aso_out0_channel (out, 1 bit) SHALL carry the index of the sink that supplied the current output beat, registered alongside the data and reset to 0.
REQ-023 Without AVALON_ST_ARB_CHANNEL_EN, the port and its register SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-024 A shared package avalon_st_pkg SHALL hold the state enumeration (IDLE/GRANT0/GRANT1) and the sink-index width constant.
REQ-025 The output register SHALL be a sub-module avalon_st_out_reg, parameterised on DATA_WIDTH, with a single-entry valid/ready pipeline stage.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Only sink 0 sends a 4-beat packet 0xA0..0xA3, ready=1 -> out0 shows 0xA0..0xA3 on four consecutive cycles starting two cycles after valid; SOP on 0xA0, EOP on 0xA3.
- Both sinks valid from reset, sink0 packet 0x10..0x12 and sink1 packet 0x20..0x22 -> sink0 packet output first, then one idle cycle, then sink1 packet; no interleave.
- Both sinks continuously offering 2-beat packets -> output alternates 0,1,0,1 across eight packets.
- Sink0 sends a 3-beat packet while aso_out0_ready toggles 1,0,0,1,1 -> each beat held while ready=0; all beats delivered in order with no loss or duplication.
- reset_reset_n pulled to 0 for one cycle after beat 2 of a 5-beat packet -> aso_out0_valid=0 next cycle, state IDLE, pointer at 0, remaining beats not emitted.
- Build with AVALON_ST_ARB_CHANNEL_EN, sink1 single-beat packet 0x55 -> aso_out0_channel=1 in the same cycle as data 0x55 with SOP=EOP=1.
